ram_arbiter: RTL and testbench

- Shares the single expansion-RAM port between several toggle-handshake requesters, such as DMA engine channels, the CPU-side register window and the SDRAM refresh/test path.
- Requester 0 has fixed highest priority. All other requesters are served round-robin. A streak limiter stops requester 0 from starving the others.
- Sits between the requesters and the RAM controller. Uses the same toggle req/ack protocol on both sides: a request is pending while req != ack.

---
 rtl/ram_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_ram_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Shares one toggle-handshake RAM port between several toggle
//               requesters: fixed priority for requester 0 (streak-limited),
//               round-robin among the rest.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int REQUESTERS = 3,
    parameter int RAM_A_BITS = 17,
    parameter int MAX_STREAK = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [REQUESTERS-1:0]            rq_req,
    output logic [REQUESTERS-1:0]            rq_ack,
    input  logic [REQUESTERS*RAM_A_BITS-1:0] rq_a,
    input  logic [REQUESTERS*8-1:0]          rq_d,
    input  logic [REQUESTERS-1:0]            rq_we,
    output logic [7:0]                       rq_q,
    output logic [RAM_A_BITS-1:0]            ram_a,
    output logic [7:0]                       ram_d,
    output logic                             ram_we,
    output logic                             ram_req,
    input  logic                             ram_ack,
    input  logic [7:0]                       ram_q,
    output logic [2:0]                       grant,
    output logic                             busy
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [REQUESTERS-1:0]   r_ack;
    logic [REQUESTERS-1:0]   w_pend;
    logic [REQUESTERS-1:0]   w_grant_oh;
    logic [7:0]              r_rq_q;
    logic [RAM_A_BITS-1:0]   r_ram_a;
    logic [7:0]              r_ram_d;
    logic                    r_ram_we;
    logic                    r_ram_req;
    logic                    r_busy;
    logic [2:0]              r_grant;
    logic [2:0]              r_rr_ptr;
    logic [3:0]              r_streak;
    logic [2:0]              w_rr_win;
    logic [2:0]              w_winner;
    logic [2:0]              w_rr_next;
    logic [3:0]              w_streak_next;
    logic                    w_found;
    logic                    w_others;
    logic                    w_pick0;
    logic                    w_issue;
    logic                    w_complete;
    logic [RAM_A_BITS-1:0]   w_sel_a;
    logic [7:0]              w_sel_d;
    logic                    w_sel_we;

    assign w_pend   = rq_req ^ r_ack;
    assign w_others = |w_pend[REQUESTERS-1:1];
    assign w_pick0  = w_pend[0] && ((r_streak < 4'(MAX_STREAK)) || !w_others);

    // Round-robin scan: first from rr_ptr upward, then wrap to 1..rr_ptr-1.
    always_comb begin
        w_rr_win = 3'd0;
        w_found  = 1'b0;
        for (int i = 1; i < REQUESTERS; i++) begin
            if (!w_found && w_pend[i] && (3'(i) >= r_rr_ptr)) begin
                w_rr_win = 3'(i);
                w_found  = 1'b1;
            end
        end
        for (int i = 1; i < REQUESTERS; i++) begin
            if (!w_found && w_pend[i] && (3'(i) < r_rr_ptr)) begin
                w_rr_win = 3'(i);
                w_found  = 1'b1;
            end
        end
        if (w_pick0 || !w_found) begin
            w_winner = 3'd0;
        end else begin
            w_winner = w_rr_win;
        end
    end

    always_comb begin
        w_rr_next = (w_winner == 3'(REQUESTERS-1)) ? 3'd1 : w_winner + 3'd1;
        if (w_winner != 3'd0) begin
            w_streak_next = 4'd0;
        end else if (w_others) begin
            w_streak_next = (r_streak >= 4'(MAX_STREAK)) ? 4'(MAX_STREAK) : r_streak + 4'd1;
        end else begin
            w_streak_next = 4'd0;
        end
    end

    always_comb begin
        w_sel_a    = '0;
        w_sel_d    = 8'd0;
        w_sel_we   = 1'b0;
        w_grant_oh = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (w_winner == 3'(i)) begin
                w_sel_a  = rq_a[i*RAM_A_BITS +: RAM_A_BITS];
                w_sel_d  = rq_d[i*8 +: 8];
                w_sel_we = rq_we[i];
            end
            w_grant_oh[i] = (r_grant == 3'(i));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_pend) begin
                    w_issue      = 1'b1;
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_ram_req == ram_ack) begin
                    w_complete   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ack     <= '0;
            r_rq_q    <= 8'd0;
            r_ram_a   <= '0;
            r_ram_d   <= 8'd0;
            r_ram_we  <= 1'b0;
            r_ram_req <= 1'b0;
            r_busy    <= 1'b0;
            r_grant   <= 3'd0;
            r_rr_ptr  <= 3'd1;
            r_streak  <= 4'd0;
        end else begin
            if (w_issue) begin
                r_ram_a   <= w_sel_a;
                r_ram_d   <= w_sel_d;
                r_ram_we  <= w_sel_we;
                r_grant   <= w_winner;
                r_ram_req <= ~r_ram_req;
                r_busy    <= 1'b1;
                r_streak  <= w_streak_next;
                if (w_winner != 3'd0) begin
                    r_rr_ptr <= w_rr_next;
                end
            end
            // Read data is captured on writes too; the controller value is don't-care there.
            if (w_complete) begin
                r_rq_q <= ram_q;
                r_ack  <= r_ack ^ w_grant_oh;
                r_busy <= 1'b0;
            end
        end
    end

    assign rq_ack  = r_ack;
    assign rq_q    = r_rq_q;
    assign ram_a   = r_ram_a;
    assign ram_d   = r_ram_d;
    assign ram_we  = r_ram_we;
    assign ram_req = r_ram_req;
    assign grant   = r_grant;
    assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Self-checking bench for ram_arbiter with a transaction-level
//               reference model and a latency-3 RAM controller model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int N   = 3;
    localparam int AW  = 17;
    localparam int MS  = 4;
    localparam int LAT = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    rq_req = '0;
    logic [N-1:0]    rq_ack;
    logic [N*AW-1:0] rq_a = '0;
    logic [N*8-1:0]  rq_d = '0;
    logic [N-1:0]    rq_we = '0;
    logic [7:0]      rq_q;
    logic [AW-1:0]   ram_a;
    logic [7:0]      ram_d;
    logic            ram_we;
    logic            ram_req;
    logic            ram_ack = 1'b0;
    logic [7:0]      ram_q = 8'd0;
    logic [2:0]      grant;
    logic            busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit [N-1:0] auto_on = '0;
    int gq[$];
    int gcyc[$];
    logic [7:0] mem [int];

    ram_arbiter #(.REQUESTERS(N), .RAM_A_BITS(AW), .MAX_STREAK(MS)) dut (
        .clk(clk), .reset(reset),
        .rq_req(rq_req), .rq_ack(rq_ack), .rq_a(rq_a), .rq_d(rq_d), .rq_we(rq_we),
        .rq_q(rq_q), .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we),
        .ram_req(ram_req), .ram_ack(ram_ack), .ram_q(ram_q),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: transaction view of the arbiter's rules.
    logic [N-1:0]  m_ack = '0;
    bit            m_busy = 0;
    int            m_grant = 0;
    int            m_rr = 1;
    int            m_streak = 0;
    logic [7:0]    m_q = 8'd0;
    logic [7:0]    m_d = 8'd0;
    logic [AW-1:0] m_a = '0;
    logic          m_we = 1'b0;
    logic          m_req = 1'b0;
    logic          prev_req = 1'b0;

    function automatic int pick(input logic [N-1:0] p, input int rr, input int streak);
        bit others;
        others = |p[N-1:1];
        if (p[0] && (streak < MS || !others)) return 0;
        for (int k = 0; k < N-1; k++) begin
            int idx;
            idx = (rr - 1 + k) % (N - 1) + 1;
            if (p[idx]) return idx;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        logic [N-1:0] p;
        int w;
        cyc++;
        if (!reset) begin
            m_ack = '0; m_busy = 0; m_grant = 0; m_rr = 1; m_streak = 0;
            m_q = 8'd0; m_d = 8'd0; m_a = '0; m_we = 1'b0; m_req = 1'b0;
        end else if (!m_busy) begin
            p = rq_req ^ m_ack;
            if (p != '0) begin
                w = pick(p, m_rr, m_streak);
                if (w != 0) begin
                    m_streak = 0;
                    m_rr = (w == N-1) ? 1 : w + 1;
                end else if (|p[N-1:1]) begin
                    m_streak = (m_streak + 1 > MS) ? MS : m_streak + 1;
                end else begin
                    m_streak = 0;
                end
                m_grant = w;
                m_a  = rq_a[w*AW +: AW];
                m_d  = rq_d[w*8 +: 8];
                m_we = rq_we[w];
                m_req = ~m_req;
                m_busy = 1;
            end
        end else if (m_req == ram_ack) begin
            m_q = ram_q;
            m_ack[m_grant] = ~m_ack[m_grant];
            m_busy = 0;
        end
        #1;
        check("rq_ack", 32'(rq_ack), 32'(m_ack));
        check("rq_q", 32'(rq_q), 32'(m_q));
        check("ram_a", 32'(ram_a), 32'(m_a));
        check("ram_d", 32'(ram_d), 32'(m_d));
        check("ram_we", 32'(ram_we), 32'(m_we));
        check("ram_req", 32'(ram_req), 32'(m_req));
        check("grant", 32'(grant), 32'(m_grant));
        check("busy", 32'(busy), 32'(m_busy));
        if (reset && ram_req != prev_req) begin
            gq.push_back(int'(grant));
            gcyc.push_back(cyc);
        end
        prev_req = ram_req;
    end

    // RAM controller model plus auto re-requesting drivers.
    initial begin : ram_model
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                ram_ack = 1'b0;
                cnt = 0;
            end else begin
                if (ram_req != ram_ack) begin
                    cnt++;
                    if (cnt == LAT) begin
                        if (ram_we) begin
                            mem[int'(ram_a)] = ram_d;
                            ram_q = 8'hEE;
                        end else begin
                            ram_q = mem.exists(int'(ram_a)) ? mem[int'(ram_a)] : (ram_a[7:0] ^ 8'h79);
                        end
                        ram_ack = ~ram_ack;
                        cnt = 0;
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (auto_on[i] && rq_req[i] == rq_ack[i]) rq_req[i] = ~rq_req[i];
                end
            end
        end
    end

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((((rq_req ^ rq_ack) != '0) || busy) && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 100) begin
            n_bad++;
            $display("FAIL %s drain: still pending after %0d cycles, required idle", name, t);
        end
    endtask

    task automatic wait_grants(input int n, input string name);
        int t;
        t = 0;
        while (gq.size() < n && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (gq.size() < n) begin
            n_bad++;
            $display("FAIL %s: got %0d grants, required %0d", name, gq.size(), n);
        end
    endtask

    initial begin : stim
        int exp_rr [4];
        int exp_st [10];
        logic ack2;
        int n2;
        exp_rr = '{1, 2, 1, 2};
        exp_st = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        repeat (3) @(negedge clk);
        check("reset rq_ack", 32'(rq_ack), 32'h0);
        check("reset ram_req", 32'(ram_req), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset grant", 32'(grant), 32'h0);
        reset = 1'b1;

        // Single read from requester 1
        @(negedge clk);
        rq_a[1*AW +: AW] = 17'h00123;
        rq_we[1] = 1'b0;
        rq_req[1] = ~rq_req[1];
        @(posedge clk); #1;
        check("read ram_req", 32'(ram_req), 32'h1);
        check("read ram_a", 32'(ram_a), 32'h00123);
        check("read grant", 32'(grant), 32'h1);
        repeat (3) @(posedge clk); #1;
        check("read rq_ack1", 32'(rq_ack[1]), 32'h1);
        check("read rq_q", 32'(rq_q), 32'h5A);
        check("read busy", 32'(busy), 32'h0);
        drain("read");

        // Write from requester 2
        @(negedge clk);
        rq_a[2*AW +: AW] = 17'h1FFFF;
        rq_d[2*8 +: 8] = 8'hC3;
        rq_we[2] = 1'b1;
        rq_req[2] = ~rq_req[2];
        @(posedge clk); #1;
        check("write ram_we", 32'(ram_we), 32'h1);
        check("write ram_d", 32'(ram_d), 32'hC3);
        check("write ram_a", 32'(ram_a), 32'h1FFFF);
        check("write grant", 32'(grant), 32'h2);
        repeat (3) @(posedge clk); #1;
        check("write rq_ack2", 32'(rq_ack[2]), 32'h1);
        drain("write");
        @(negedge clk);
        rq_we[2] = 1'b0;
        rq_a[1*AW +: AW] = 17'h00A01;
        rq_a[2*AW +: AW] = 17'h00B02;

        // Round-robin between requesters 1 and 2
        gq.delete(); gcyc.delete();
        auto_on = 3'b110;
        wait_grants(4, "rr count");
        auto_on = '0;
        drain("rr");
        if (gq.size() >= 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("rr grant[%0d]", i), 32'(gq[i]), 32'(exp_rr[i]));
            for (int i = 0; i < 3; i++) check($sformatf("rr spacing[%0d]", i), 32'(gcyc[i+1] - gcyc[i]), 32'd4);
        end

        // Streak limit with requesters 0 and 1 both busy
        @(negedge clk);
        gq.delete(); gcyc.delete();
        auto_on = 3'b011;
        wait_grants(10, "streak count");
        auto_on = '0;
        drain("streak");
        if (gq.size() >= 10) begin
            for (int i = 0; i < 10; i++) check($sformatf("streak grant[%0d]", i), 32'(gq[i]), 32'(exp_st[i]));
        end

        // Requester 2 double-toggles while requester 1 is served
        @(negedge clk);
        gq.delete(); gcyc.delete();
        ack2 = rq_ack[2];
        rq_req[1] = ~rq_req[1];
        @(posedge clk);
        @(negedge clk);
        rq_req[2] = ~rq_req[2];
        @(negedge clk);
        rq_req[2] = ~rq_req[2];
        drain("cancel");
        n2 = 0;
        foreach (gq[i]) if (gq[i] == 2) n2++;
        check("cancel rq_ack2", 32'(rq_ack[2]), 32'(ack2));
        check("cancel grants to 2", 32'(n2), 32'h0);
        check("cancel grant count", 32'(gq.size()), 32'h1);

        // Reset asserted two cycles into a transfer
        @(negedge clk);
        rq_req[1] = ~rq_req[1];
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        rq_req = '0;
        #1;
        check("rst rq_ack", 32'(rq_ack), 32'h0);
        check("rst rq_q", 32'(rq_q), 32'h0);
        check("rst ram_a", 32'(ram_a), 32'h0);
        check("rst ram_d", 32'(ram_d), 32'h0);
        check("rst ram_we", 32'(ram_we), 32'h0);
        check("rst ram_req", 32'(ram_req), 32'h0);
        check("rst grant", 32'(grant), 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rq_a[1*AW +: AW] = 17'h00456;
        rq_req[1] = ~rq_req[1];
        @(posedge clk); #1;
        check("post-rst ram_req", 32'(ram_req), 32'h1);
        check("post-rst ram_a", 32'(ram_a), 32'h00456);
        check("post-rst grant", 32'(grant), 32'h1);
        repeat (3) @(posedge clk); #1;
        check("post-rst rq_ack1", 32'(rq_ack[1]), 32'h1);
        check("post-rst rq_q", 32'(rq_q), 32'h2F);
        drain("post-rst");

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
